spi_flash_port: RTL and testbench

IO-bus peripheral that replaces bit-banged access to the configuration flash pins (SCK/MOSI/MISO/CS) with a byte-wide SPI mode-0 shifter. It sits directly downstream of the registered IO strobe stage in `top`. It consumes the one-cycle-delayed write/read strobes and the write data (`io_wr_`, `io_rd_`, `dout_`), each qualified by an address bit. It produces a status/data word that `top` ORs into `io_din`.

---
 rtl/spi_flash_port.sv | 146 ++++++++++++++
 tb/tb_spi_flash_port.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_port.sv
// Byte-wide SPI mode-0 shifter for the configuration flash pins.
// Software controls chip-select; each data write shifts one byte out and one byte in.
module spi_flash_port #(
  parameter int unsigned CLKDIV = 3
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       wr_data,
  input  logic       wr_ctrl,
  input  logic       rd_data,
  input  logic [7:0] din,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bitn_q, bitn_d;
  logic [7:0] sr_q, sr_d;
  logic       rbit_q, rbit_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;
  logic       miso_s1_q, miso_s1_d;
  logic       miso_s2_q, miso_s2_d;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q   <= S_IDLE;
      div_q     <= 8'h00;
      bitn_q    <= 3'd0;
      sr_q      <= 8'h00;
      rbit_q    <= 1'b0;
      rx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bitn_q    <= bitn_d;
      sr_q      <= sr_d;
      rbit_q    <= rbit_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      miso_s1_q <= miso_s1_d;
      miso_s2_q <= miso_s2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bitn_d    = bitn_q;
    sr_d      = sr_q;
    rbit_d    = rbit_q;
    rx_data_d = rx_data_q;
    done_d    = done_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    miso_s1_d = miso;
    miso_s2_d = miso_s1_q;

    // Acknowledge first so a completion in the same cycle overrides it.
    if (rd_data) done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_ctrl) cs_n_d = ~din[0];
        if (wr_data) begin
          sr_d    = din;
          bitn_d  = 3'd0;
          div_d   = 8'h00;
          done_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = din[7];
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (div_q == DIV_LAST) begin
          rbit_d  = miso_s2_q;
          div_d   = 8'h00;
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (div_q == DIV_LAST) begin
          sr_d  = {sr_q[6:0], rbit_q};
          div_d = 8'h00;
          sck_d = 1'b0;
          if (bitn_q == 3'd7) begin
            rx_data_d = {sr_q[6:0], rbit_q};
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bitn_d  = bitn_q + 3'd1;
            mosi_d  = sr_q[6];
            state_d = S_LOW;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_flash_port.sv
// Scoreboard bench for spi_flash_port: loopback and external mode-0 slave,
// done handshake, ignored writes, async reset mid-transfer.
module tb_spi_flash_port;

  localparam int C        = 3;
  localparam int BYTE_CYC = 16 * C;

  logic       clk = 1'b0;
  logic       resetq = 1'b0;
  logic       wr_data = 1'b0;
  logic       wr_ctrl = 1'b0;
  logic       rd_data = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] rx_data;
  logic       busy, done, sck, mosi, miso, cs_n;

  // slave model: shifts out slave_byte MSB first, advancing on each SCK fall
  logic       loopback = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int         slave_base = 0;
  int         fall_count = 0;
  logic       slave_bit;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];
  logic       bit_q[$];

  spi_flash_port #(.CLKDIV(C)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .wr_data (wr_data),
    .wr_ctrl (wr_ctrl),
    .rd_data (rd_data),
    .din     (din),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sck     (sck),
    .mosi    (mosi),
    .miso    (miso),
    .cs_n    (cs_n)
  );

  always #5 clk = ~clk;

  always @(negedge sck) fall_count <= fall_count + 1;

  always_comb begin
    int k;
    k = fall_count - slave_base;
    slave_bit = (k >= 0 && k < 8) ? slave_byte[3'(7 - k)] : 1'b0;
  end

  assign miso = loopback ? mosi : slave_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: MOSI bit per SCK rise, SCK high width, busy width, result on done rise
  int   high_len = 0;
  int   busy_len = 0;
  logic sck_p = 1'b0, busy_p = 1'b0, done_p = 1'b0;

  always @(negedge clk) begin
    logic       eb;
    logic [7:0] er;
    if (!resetq) begin
      high_len = 0;
      busy_len = 0;
      sck_p    = 1'b0;
      busy_p   = 1'b0;
      done_p   = 1'b0;
    end else begin
      if (sck && !sck_p) begin
        if (bit_q.size() == 0) check("mosi_unexpected_rise", 32'd1, 32'd0);
        else begin
          eb = bit_q.pop_front();
          check("mosi_bit", 32'(mosi), 32'(eb));
        end
      end
      if (sck) high_len++;
      if (!sck && sck_p) begin
        check("sck_high_len", 32'(high_len), 32'(C));
        high_len = 0;
      end
      if (busy) busy_len++;
      if (!busy && busy_p) begin
        check("busy_len", 32'(busy_len), 32'(BYTE_CYC));
        busy_len = 0;
      end
      if (done && !done_p) begin
        if (exp_q.size() == 0) check("rx_unexpected_done", 32'd1, 32'd0);
        else begin
          er = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(er));
        end
      end
      sck_p  = sck;
      busy_p = busy;
      done_p = done;
    end
  end

  // called at a negedge; returns at the negedge just after the start edge T0
  task automatic start_byte(input logic [7:0] tx, input logic lb, input logic [7:0] sb);
    loopback   = lb;
    slave_byte = sb;
    slave_base = fall_count;
    din        = tx;
    wr_data    = 1'b1;
    for (int i = 7; i >= 0; i--) bit_q.push_back(tx[i]);
    exp_q.push_back(lb ? tx : sb);
    @(posedge clk);
    @(negedge clk);
    wr_data = 1'b0;
  endtask

  task automatic set_cs(input logic sel);
    din     = {7'b0, sel};
    wr_ctrl = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_ctrl = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_data = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rd_data = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < BYTE_CYC + 8) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] tx, sb;
    logic       lb;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'h00);
    resetq = 1'b1;
    @(negedge clk);

    set_cs(1'b1);
    check("cs_select", 32'(cs_n), 32'd0);

    // basic loopback with cycle-exact timing
    start_byte(8'hA5, 1'b1, 8'h00);
    check("start_busy", 32'(busy), 32'd1);
    check("start_mosi", 32'(mosi), 32'd1);
    check("start_sck", 32'(sck), 32'd0);
    repeat (C - 1) @(negedge clk);
    check("sck_before_rise", 32'(sck), 32'd0);
    @(negedge clk);
    check("sck_first_rise", 32'(sck), 32'd1);
    repeat (BYTE_CYC - C - 1) @(negedge clk);
    check("busy_before_end", 32'(busy), 32'd1);
    check("done_before_end", 32'(done), 32'd0);
    @(negedge clk);
    check("busy_at_end", 32'(busy), 32'd0);
    check("done_at_end", 32'(done), 32'd1);
    check("sck_at_end", 32'(sck), 32'd0);
    check("rx_a5", 32'(rx_data), 32'hA5);

    pulse_rd();
    check("done_ack", 32'(done), 32'd0);

    // external slave returns 3C while host sends 00
    start_byte(8'h00, 1'b0, 8'h3C);
    wait_done();
    check("rx_slave_3c", 32'(rx_data), 32'h3C);

    // writes while busy must be ignored
    start_byte(8'hC3, 1'b1, 8'h00);
    repeat (10) @(negedge clk);
    din = 8'hFF;
    wr_data = 1'b1;
    @(negedge clk);
    wr_data = 1'b0;
    repeat (7) @(negedge clk);
    din = 8'h00;
    wr_ctrl = 1'b1;
    @(negedge clk);
    wr_ctrl = 1'b0;
    check("cs_held_busy", 32'(cs_n), 32'd0);
    wait_done();
    check("rx_ignored_writes", 32'(rx_data), 32'hC3);
    check("cs_after_ignored", 32'(cs_n), 32'd0);

    // rd_data on the completion edge: completion wins
    pulse_rd();
    start_byte(8'h96, 1'b1, 8'h00);
    repeat (BYTE_CYC - 1) @(negedge clk);
    rd_data = 1'b1;
    @(negedge clk);
    rd_data = 1'b0;
    check("done_wins_rd", 32'(done), 32'd1);

    // a new transfer clears done immediately
    start_byte(8'h3C, 1'b1, 8'h00);
    check("done_cleared_by_wr", 32'(done), 32'd0);
    wait_done();

    // randomized back-to-back bytes, mixed loopback and slave
    for (int it = 0; it < 10; it++) begin
      tx = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      lb = 1'($urandom_range(0, 1));
      check("gap_sck_low", 32'(sck), 32'd0);
      start_byte(tx, lb, sb);
      wait_done();
    end

    // async reset in the middle of the fourth bit
    start_byte(8'h1F, 1'b1, 8'h00);
    repeat (6 * C + 1) @(negedge clk);
    #2 resetq = 1'b0;
    #1;
    check("arst_sck", 32'(sck), 32'd0);
    check("arst_mosi", 32'(mosi), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_rx", 32'(rx_data), 32'h00);
    bit_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    set_cs(1'b1);
    start_byte(8'h5A, 1'b1, 8'h00);
    wait_done();
    check("rx_after_reset", 32'(rx_data), 32'h5A);

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("bit_q_drained", 32'(bit_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
